// File: rtl/video_frame_conditioner_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// Purpose : AXI4-Stream bundle used on both sides of video_frame_conditioner.
//           For video, tuser marks start of frame and tlast marks end of line.
// Signals : tvalid, tready, tdata[TDATA_WIDTH], tstrb/tkeep[TDATA_WIDTH/8],
//           tlast, tuser, tid[TID_WIDTH], tdest[TDEST_WIDTH]
// Modports: master (drives payload, samples tready)
//           slave  (samples payload, drives tready)
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 16,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic                       tuser;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/video_frame_conditioner.sv
// -----------------------------------------------------------------------------
// video_frame_conditioner
// Purpose : Forces every video frame to exactly FRAME_RES_X x FRAME_RES_Y
//           output beats. Waits for SOF, pads short lines / short frames with
//           PAD_VALUE, truncates long lines and discards surplus lines, so the
//           downstream frame-buffer writer sees fixed geometry.
// Ports   : clk_i          - single clock
//           rst_n_i        - asynchronous active-low reset
//           video_i        - raw stream (slave), tuser = SOF, tlast = EOL
//           video_o        - conditioned stream (master), one register stage
//           short_lines_o  - 16-bit saturating count of padded lines   (stats)
//           long_lines_o   - 16-bit saturating count of truncated lines(stats)
//           short_frames_o - 16-bit saturating count of padded frames  (stats)
// Config  : define VIDEO_FRAME_COND_STATS_EN to add the three stats ports.
// -----------------------------------------------------------------------------
module video_frame_conditioner #(
    parameter int                     FRAME_RES_X = 1920,
    parameter int                     FRAME_RES_Y = 1080,
    parameter int                     TDATA_WIDTH = 16,
    parameter logic [TDATA_WIDTH-1:0] PAD_VALUE   = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o
`ifdef VIDEO_FRAME_COND_STATS_EN
    ,
    output logic [15:0]   short_lines_o,
    output logic [15:0]   long_lines_o,
    output logic [15:0]   short_frames_o
`endif
);

    localparam int XW = $clog2(FRAME_RES_X);
    localparam int YW = $clog2(FRAME_RES_Y);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_RES_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_RES_Y - 1);

    typedef enum logic [2:0] {
        WAIT_SOF,
        PASS,
        PAD_LINE,
        DROP_LINE,
        PAD_FRAME
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   run;        // low during reset and one cycle after, keeps tready low
    logic [XW-1:0]          x_cnt;      // counts output beats
    logic [YW-1:0]          y_cnt;

    logic                   out_valid;
    logic [TDATA_WIDTH-1:0] out_data;
    logic                   out_user;
    logic                   out_last;

    logic                   load_en;
    logic                   in_ready;
    logic                   emit;
    logic                   emit_pad;
    logic                   in_sof;
    logic                   at_origin;
    logic                   at_eol;
    logic                   at_eof;

    assign load_en   = !out_valid || video_o.tready;
    assign in_sof    = video_i.tvalid && video_i.tuser;
    assign at_origin = (x_cnt == '0) && (y_cnt == '0);
    assign at_eol    = (x_cnt == X_LAST);
    assign at_eof    = at_eol && (y_cnt == Y_LAST);

    // Sideband inputs carry nothing this block needs.
    logic unused_sideband;
    assign unused_sideband = ^{video_i.tstrb, video_i.tkeep, video_i.tid, video_i.tdest};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state <= WAIT_SOF;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        if (run) begin
            case (state)
                WAIT_SOF: begin
                    if (in_sof)
                        state_next = PASS;
                end
                PASS: begin
                    if (in_sof && !at_origin)
                        state_next = PAD_FRAME;               // early SOF, beat held back
                    else if (emit) begin
                        if (at_eof)
                            state_next = video_i.tlast ? WAIT_SOF : DROP_LINE;
                        else if (video_i.tlast && !at_eol)
                            state_next = PAD_LINE;
                        else if (at_eol && !video_i.tlast)
                            state_next = DROP_LINE;
                    end
                end
                PAD_LINE: begin
                    // A padded final line completes the frame; input EOL was
                    // already seen, so the next frame must start from SOF.
                    if (emit && at_eol)
                        state_next = at_eof ? WAIT_SOF : PASS;
                end
                DROP_LINE: begin
                    // Counters sit at the origin here only after a frame's last
                    // line overran, so origin means "frame already complete".
                    if (in_sof)
                        state_next = at_origin ? PASS : PAD_FRAME;
                    else if (video_i.tvalid && video_i.tlast)
                        state_next = at_origin ? WAIT_SOF : PASS;
                end
                PAD_FRAME: begin
                    if (emit && at_eof)
                        state_next = PASS;
                end
                default: state_next = WAIT_SOF;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (input ready, beat emission, pad select)
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        emit     = 1'b0;
        emit_pad = 1'b0;
        if (run) begin
            case (state)
                WAIT_SOF, DROP_LINE: begin
                    // Discard everything except an SOF, which waits for PASS.
                    in_ready = !in_sof;
                end
                PASS: begin
                    in_ready = load_en && !(in_sof && !at_origin);
                    emit     = video_i.tvalid && in_ready;
                end
                PAD_LINE, PAD_FRAME: begin
                    emit     = load_en;
                    emit_pad = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign video_i.tready = in_ready;

    // ------------------------------------------------------------------------
    // Output-beat counters: advance once per beat loaded into the output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (emit) begin
            if (at_eol) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register stage: loads only when empty or being drained
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= emit;
            if (emit) begin
                out_data <= emit_pad ? PAD_VALUE : video_i.tdata;
                out_user <= at_origin;
                out_last <= at_eol;
            end
        end
    end

    assign video_o.tvalid = out_valid;
    assign video_o.tdata  = out_data;
    assign video_o.tuser  = out_user;
    assign video_o.tlast  = out_last;
    assign video_o.tstrb  = '1;
    assign video_o.tkeep  = '1;
    assign video_o.tid    = '0;
    assign video_o.tdest  = '0;

`ifdef VIDEO_FRAME_COND_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating event counters, bumped on entry to each corrective state
    // ------------------------------------------------------------------------
    logic enter_pad_line;
    logic enter_drop_line;
    logic enter_pad_frame;

    assign enter_pad_line  = (state_next == PAD_LINE)  && (state != PAD_LINE);
    assign enter_drop_line = (state_next == DROP_LINE) && (state != DROP_LINE);
    assign enter_pad_frame = (state_next == PAD_FRAME) && (state != PAD_FRAME);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            short_lines_o  <= '0;
            long_lines_o   <= '0;
            short_frames_o <= '0;
        end else begin
            if (enter_pad_line && (short_lines_o != 16'hFFFF))
                short_lines_o <= short_lines_o + 1'b1;
            if (enter_drop_line && (long_lines_o != 16'hFFFF))
                long_lines_o <= long_lines_o + 1'b1;
            if (enter_pad_frame && (short_frames_o != 16'hFFFF))
                short_frames_o <= short_frames_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_video_frame_conditioner.sv
// -----------------------------------------------------------------------------
// tb_video_frame_conditioner
// Directed stimulus on an 8x4 geometry with PAD_VALUE = 16'hDEAD. Expected
// output beats are queued as stimulus is issued; a monitor pops and compares
// each beat the DUT hands over on video_o.
// -----------------------------------------------------------------------------
module tb_video_frame_conditioner;

    localparam int          X   = 8;
    localparam int          Y   = 4;
    localparam int          W   = 16;
    localparam logic [15:0] PAD = 16'hDEAD;

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(W)) vin ();
    axi4_stream_if #(.TDATA_WIDTH(W)) vout ();

`ifdef VIDEO_FRAME_COND_STATS_EN
    logic [15:0] short_lines;
    logic [15:0] long_lines;
    logic [15:0] short_frames;
`endif

    video_frame_conditioner #(
        .FRAME_RES_X (X),
        .FRAME_RES_Y (Y),
        .TDATA_WIDTH (W),
        .PAD_VALUE   (PAD)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .video_i        (vin),
        .video_o        (vout)
`ifdef VIDEO_FRAME_COND_STATS_EN
        ,
        .short_lines_o  (short_lines),
        .long_lines_o   (long_lines),
        .short_frames_o (short_frames)
`endif
    );

    beat_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Output-side ready: always 1, or high about 30 % of cycles in random mode.
    always begin
        vout.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            vout.tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: a handshake seen at the falling edge completes on the next rise.
    always @(negedge clk) begin
        beat_t e;
        beat_t got;
        if (rst_n_i && vout.tvalid && vout.tready) begin
            got = '{data: vout.tdata, user: vout.tuser, last: vout.tlast};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: actual=%h expected=none (t=%0t)", got, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", 32'(got), 32'(e));
                check("out_sideband", 32'({vout.tkeep, vout.tstrb, vout.tid, vout.tdest}), 32'h3C);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] d, input logic u, input logic l);
        int n;
        n = 0;
        vin.tvalid = 1'b1;
        vin.tdata  = d;
        vin.tuser  = u;
        vin.tlast  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!vin.tready && n < 1000);
        if (!vin.tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: actual=no_ready expected=ready data=%h", d);
        end
        @(posedge clk);
        #1;
        vin.tvalid = 1'b0;
        vin.tuser  = 1'b0;
        vin.tlast  = 1'b0;
    endtask

    // Sends n beats base..base+n-1; tlast on index last_idx (-1 for none).
    task automatic send_line(input int base, input int n, input bit sof, input int last_idx);
        for (int i = 0; i < n; i++)
            send(16'(base + i), sof && (i == 0), i == last_idx);
    endtask

    task automatic push(input logic [15:0] d, input logic u, input logic l);
        exp_q.push_back('{data: d, user: u, last: l});
    endtask

    // Expected forwarded pixels of one line: first min(n, X) input beats.
    task automatic push_line(input int base, input int n, input bit sof);
        for (int i = 0; i < n && i < X; i++)
            push(16'(base + i), sof && (i == 0), i == X - 1);
    endtask

    // Expected pad beats starting at column x0.
    task automatic push_pad(input int x0, input int n);
        for (int i = 0; i < n; i++)
            push(PAD, 1'b0, ((x0 + i) % X) == X - 1);
    endtask

    task automatic push_clean_frame(input int base);
        for (int y = 0; y < Y; y++)
            push_line(base + y * X, X, y == 0);
    endtask

    task automatic send_clean_frame(input int base);
        for (int y = 0; y < Y; y++)
            send_line(base + y * X, X, y == 0, X - 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vin.tvalid = 1'b0;
        vin.tdata  = '0;
        vin.tuser  = 1'b0;
        vin.tlast  = 1'b0;
        vin.tstrb  = '1;
        vin.tkeep  = '1;
        vin.tid    = '0;
        vin.tdest  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(vout.tvalid), 32'd0);
        check("reset_in_ready", 32'(vin.tready), 32'd0);
`ifdef VIDEO_FRAME_COND_STATS_EN
        check("reset_stats", 32'({short_lines, long_lines}), 32'd0);
`endif
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame 0..31, with a one-cycle latency check on the SOF beat.
        push_clean_frame(0);
        send(16'd0, 1'b1, 1'b0);
        check("latency_valid", 32'(vout.tvalid), 32'd1);
        check("latency_data", 32'({vout.tdata, vout.tuser}), 32'h00001);
        for (int i = 1; i < X * Y; i++)
            send(16'(i), 1'b0, (i % X) == X - 1);
        wait_drain("drain_clean_frame");

        // Junk before SOF is dropped; frame 100.. follows intact.
        for (int i = 0; i < 5; i++)
            send(16'h0BAD, 1'b0, i == 2);
        push_clean_frame(100);
        send_clean_frame(100);
        wait_drain("drain_junk_then_sof");

        // Short line 1 (5 px) and long line 2 (11 px).
        push_line(300, X, 1'b1);
        push_line(308, 5, 1'b0);
        push_pad(5, 3);
        push_line(320, 11, 1'b0);
        push_line(340, X, 1'b0);
        send_line(300, X, 1'b1, X - 1);
        send_line(308, 5, 1'b0, 4);
        send_line(320, 11, 1'b0, 10);
        send_line(340, X, 1'b0, X - 1);
        wait_drain("drain_short_long_lines");
`ifdef VIDEO_FRAME_COND_STATS_EN
        check("stat_short_lines", 32'(short_lines), 32'd1);
        check("stat_long_lines", 32'(long_lines), 32'd1);
`endif

        // Early SOF after two lines: 16 pad beats, then frame 500.. whose
        // last line overruns (10 px) and is truncated at the frame end.
        push_line(400, X, 1'b1);
        push_line(408, X, 1'b0);
        push_pad(0, 2 * X);
        for (int y = 0; y < Y; y++)
            push_line(500 + y * 16, X, y == 0);
        send_line(400, X, 1'b1, X - 1);
        send_line(408, X, 1'b0, X - 1);
        for (int y = 0; y < Y - 1; y++)
            send_line(500 + y * 16, X, y == 0, X - 1);
        send_line(500 + (Y - 1) * 16, 10, 1'b0, 9);
        send_line(900, 3, 1'b0, 2);          // surplus line, discarded
        wait_drain("drain_short_frame");
`ifdef VIDEO_FRAME_COND_STATS_EN
        check("stat_short_frames", 32'(short_frames), 32'd1);
        check("stat_long_lines_2", 32'(long_lines), 32'd2);
`endif

        // Random output back-pressure.
        rand_ready = 1'b1;
        push_clean_frame(600);
        send_clean_frame(600);
        wait_drain("drain_random_ready");

        // Partial frame, then reset mid-line 2.
        push_line(700, X, 1'b1);
        push_line(708, X, 1'b0);
        push_line(716, 3, 1'b0);
        send_line(700, X, 1'b1, X - 1);
        send_line(708, X, 1'b0, X - 1);
        send_line(716, 3, 1'b0, -1);
        wait_drain("drain_before_reset");
        rst_n_i = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(vout.tvalid), 32'd0);
        check("midreset_in_ready", 32'(vin.tready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(16'(719 + i), 1'b0, 1'b0);
            check("post_reset_idle", 32'(vout.tvalid), 32'd0);
        end
        push_clean_frame(800);
        send_clean_frame(800);
        wait_drain("drain_after_reset");
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
